// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run/halt sequencer for the single-cycle processor.
// Streams a program image into imem, holds the processor in reset for
// RST_CYCLES cycles, then runs it (free-running or single-step) until a
// halt opcode is fetched. It also counts the enabled (executed) cycles.
//
// Optional feature: define PROC_RUN_WATCHDOG_EN to add parameter MAX_CYCLES.
// A run that reaches MAX_CYCLES enabled cycles without halting is then
// stopped with timeout=1. Without the macro, timeout is tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start                    begin load phase (from IDLE or HALT)
//   step_mode, step_req      single-step select / one-instruction request
//   load_valid/ready/data/last  program image stream (valid/ready)
//   imem_we/addr/wdata       imem write port
//   proc_rst, proc_en        processor reset (active high) and clock-enable
//   proc_instr               instruction currently fetched by the processor
//   busy, halted             status (LOAD/PRST/RUN, HALT)
//   cycle_count              saturating count of enabled cycles since start
//   timeout                  watchdog fired
module proc_run_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 2,
    parameter logic [5:0]  HALT_OP    = 6'h3F
`ifdef PROC_RUN_WATCHDOG_EN
    ,
    parameter int unsigned MAX_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              proc_rst,
    output logic              proc_en,
    input  logic [DATA_W-1:0] proc_instr,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              timeout
);

    localparam int unsigned    RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRST,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [RC_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              halt_op_c;
    logic              unused_instr_c;

    // Saturating increment of the executed-cycle counter
    assign cnt_inc_c = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

    // Only the opcode field of the fetched instruction matters here
    assign halt_op_c      = (proc_instr[DATA_W-1 -: 6] == HALT_OP);
    assign unused_instr_c = ^proc_instr[DATA_W-7:0];

`ifdef PROC_RUN_WATCHDOG_EN
    logic wd_hit_c;
    assign wd_hit_c = (cnt_inc_c == CNT_W'(MAX_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // Sequencer state and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            wr_addr     <= '0;
            rst_cnt     <= '0;
            load_ready  <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            proc_rst    <= 1'b1;
            proc_en     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
`ifdef PROC_RUN_WATCHDOG_EN
            timeout     <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state       <= S_LOAD;
                        wr_addr     <= '0;
                        imem_addr   <= '0;
                        cycle_count <= '0;
                        load_ready  <= 1'b1;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                        proc_rst    <= 1'b1;
                        proc_en     <= 1'b0;
`ifdef PROC_RUN_WATCHDOG_EN
                        timeout     <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    // Write lands one cycle after the transfer; address wraps freely
                    if (load_valid && load_ready) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wr_addr;
                        imem_wdata <= load_data;
                        wr_addr    <= wr_addr + ADDR_W'(1);
                        if (load_last) begin
                            state      <= S_PRST;
                            load_ready <= 1'b0;
                            rst_cnt    <= '0;
                        end
                    end
                end
                S_PRST: begin
                    if (rst_cnt == RC_LAST) begin
                        state    <= S_RUN;
                        proc_rst <= 1'b0;
                        proc_en  <= ~step_mode;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                S_RUN: begin
                    if (proc_en) begin
                        cycle_count <= cnt_inc_c;
                    end
                    // The halting instruction itself is counted above
                    if (proc_en && halt_op_c) begin
                        state   <= S_HALT;
                        proc_en <= 1'b0;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end
`ifdef PROC_RUN_WATCHDOG_EN
                    else if (proc_en && wd_hit_c) begin
                        state   <= S_HALT;
                        proc_en <= 1'b0;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                        timeout <= 1'b1;
                    end
`endif
                    else begin
                        // A step request seen while already enabled is dropped
                        proc_en <= step_mode ? (step_req & ~proc_en) : 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Run/halt sequencer for the single-cycle processor.
- Streams a program image into instruction memory over a valid/ready handshake.
- Holds the processor in reset for a fixed number of cycles, then runs it (free-running or single-step) until a halt opcode is fetched.
- Reports the executed-cycle count.
- Sits between the top-level bench/host and the processor's reset, clock-enable and imem write port.

Parameters:
ADDR_W, 8, imem word-address width
DATA_W, 32, instruction width
CNT_W, 16, executed-cycle counter width
RST_CYCLES, 2, cycles proc_rst is held high before run (>=1)
HALT_OP, 6'h3F, opcode in instr[DATA_W-1:DATA_W-6] that halts

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-low reset (0 = reset)
start  input  1  pulse: begin load phase from IDLE or HALT
step_mode  input  1  1 = single-step, 0 = free run; sampled on entry to RUN
step_req  input  1  pulse: execute one instruction while step_mode=1
load_valid  input  1  load word valid
load_ready  output  1  controller accepts load word
load_data  input  DATA_W  instruction word
load_last  input  1  marks final word of image
imem_we  output  1  imem write strobe
imem_addr  output  ADDR_W  imem write address
imem_wdata  output  DATA_W  imem write data
proc_rst  output  1  active-high reset to processor
proc_en  output  1  processor clock-enable (PC/regfile/mem update)
proc_instr  input  DATA_W  instruction currently fetched by processor
busy  output  1  high in LOAD, PRST, RUN
halted  output  1  high in HALT
cycle_count  output  CNT_W  enabled cycles executed since last start
timeout  output  1  watchdog fired (only with optional feature)

Behaviour:
- Reset (rst=0 at posedge): state IDLE; load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, proc_rst=1, proc_en=0, busy=0, halted=0, cycle_count=0, timeout=0. Reset mid-operation aborts any state immediately; a partially written image is left in imem.
- All outputs registered.
- IDLE: proc_rst=1. start -> LOAD; imem_addr cleared, cycle_count cleared.
- LOAD: load_ready=1.
  - Transfer when load_valid & load_ready: next cycle imem_we=1, imem_wdata=load_data, imem_addr=current word address; address then increments.
  - Address wraps to 0 after 2^ADDR_W-1; no error.
  - Transfer with load_last=1 -> PRST; load_ready drops the following cycle.
  - load_valid low: stall, no write.
- PRST: proc_rst=1, proc_en=0 for exactly RST_CYCLES cycles (internal counter), then RUN.
- RUN: proc_rst=0.
  - Free run: proc_en=1 every cycle.
  - Step mode: proc_en=1 for exactly one cycle per step_req pulse. step_req arriving while proc_en is already high is ignored. step_req outside RUN is ignored.
  - cycle_count increments on every cycle with proc_en=1 and saturates at all-ones.
  - Halt detect: when proc_en=1 and proc_instr opcode == HALT_OP -> HALT next cycle. The halt instruction itself is counted.
- HALT: proc_en=0, proc_rst=0 (processor state preserved for inspection), halted=1, cycle_count frozen. start -> LOAD (clears count).
- start in LOAD/PRST/RUN: ignored.
- step_mode changes during RUN take effect next cycle.

Optional Feature:
- Macro: PROC_RUN_WATCHDOG_EN.
- Defined:
  - Adds parameter MAX_CYCLES (default 1024).
  - When cycle_count reaches MAX_CYCLES in RUN without a halt: go to HALT with timeout=1, halted=1.
  - timeout cleared by start or reset.
- Undefined: timeout tied 0; no watchdog logic; the run ends only on halt opcode or reset.

Test Plan:
- Reset: rst=0 for 2 cycles -> IDLE, proc_rst=1, proc_en=0, cycle_count=0, load_ready=0.
- Load 4 words (0x11111111..0x44444444, last on word 4) with load_valid held -> imem_we pulses at addr 0..3 with matching data; PRST lasts exactly 2 cycles; RUN begins.
- Free run, halt opcode (0xFC000000) presented on 5th enabled cycle -> halted=1 next cycle, cycle_count=5, proc_en=0, proc_rst=0.
- Step mode, 3 step_req pulses 4 cycles apart, halt on 3rd -> exactly 3 single-cycle proc_en pulses, cycle_count=3, HALT.
- rst=0 mid-LOAD after 2 words, then restart with a 1-word image -> imem_addr restarts at 0, single write, run proceeds.
- PROC_RUN_WATCHDOG_EN, MAX_CYCLES=8, no halt opcode -> after 8 enabled cycles timeout=1, halted=1, cycle_count=8; subsequent start clears timeout.
